// File: rtl/ir_fetch_unit_if.sv
// Instruction-memory read handshake bundle (MFA/MOC) between the fetch unit and memory.
interface ir_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_mfa;
  logic [31:0] mem_data_in;
  logic        mem_moc;

  modport master (output mem_addr, output mem_mfa, input mem_data_in, input mem_moc);
  modport slave  (input mem_addr, input mem_mfa, output mem_data_in, output mem_moc);
endinterface

// File: rtl/ir_fetch_unit.sv
// Instruction fetch handshake + IR stage with MIPS field decode.
// Optional WAIT-state timeout enabled by defining IR_FETCH_TIMEOUT_EN.
module ir_fetch_unit #(
  parameter logic [31:0] RESET_IR       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch,
  input  logic                    flush,
  input  logic [31:0]             pc_in,
  ir_fetch_unit_if.master         mem,
  output logic [31:0]             ir_out,
  output logic [5:0]              opcode,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [4:0]              shamt,
  output logic [5:0]              funct,
  output logic                    ir_valid,
  output logic                    busy,
  output logic                    fetch_done,
  output logic                    align_err,
  output logic                    fetch_error
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ir_fetch_unit: TIMEOUT_CYCLES out of range 2..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        align_q, align_d;
  logic        ferr_q, ferr_d;
`ifdef IR_FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    align_d = align_q;
    ferr_d  = ferr_q;
`ifdef IR_FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (fetch && !flush) begin
          state_d = WAIT;
          addr_d  = {pc_in[31:2], 2'b00};
          align_d = |pc_in[1:0];
          ferr_d  = 1'b0;
`ifdef IR_FETCH_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      WAIT: begin
        if (mem.mem_moc) begin
          ir_d    = mem.mem_data_in;
          valid_d = 1'b1;
          state_d = DONE;
        end
`ifdef IR_FETCH_TIMEOUT_EN
        // Last allowed cycle without MOC: abandon the fetch, IR keeps its old word.
        else if (cnt_q == TO_LAST) begin
          ferr_d  = !flush;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including a same-cycle MOC capture.
    if (flush) begin
      state_d = IDLE;
      ir_d    = RESET_IR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      ir_q    <= RESET_IR;
      valid_q <= 1'b0;
      align_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef IR_FETCH_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      align_q <= align_d;
      ferr_q  <= ferr_d;
`ifdef IR_FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_mfa  = (state_q == WAIT);
  assign busy         = (state_q == WAIT) || (state_q == DONE);
  assign fetch_done   = (state_q == DONE);
  assign ir_valid     = valid_q;
  assign align_err    = align_q;
`ifdef IR_FETCH_TIMEOUT_EN
  assign fetch_error  = ferr_q;
`else
  assign fetch_error  = 1'b0;
`endif

  assign ir_out = ir_q;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Directed bench for ir_fetch_unit: handshake latency, wait states, flush, alignment, reset, timeout.
module tb_ir_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, fetch, flush;
  logic [31:0] pc_in, ir_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        ir_valid, busy, fetch_done, align_err, fetch_error;
  int          tests = 0;
  int          fails = 0;

  ir_fetch_unit_if mif ();

  ir_fetch_unit #(.RESET_IR(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .flush(flush), .pc_in(pc_in), .mem(mif),
    .ir_out(ir_out), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .ir_valid(ir_valid), .busy(busy), .fetch_done(fetch_done), .align_err(align_err),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; fetch = 1'b0; flush = 1'b0; pc_in = 32'h0;
    mif.mem_moc = 1'b0; mif.mem_data_in = 32'h0;
    tick(); tick();
    reset = 1'b0;
    tests++; if (ir_out !== 32'h0) begin fails++; $display("FAIL reset_ir got %h exp %h", ir_out, 32'h0); end
    tests++; if ({mif.mem_addr, mif.mem_mfa, ir_valid, busy, fetch_done, align_err, fetch_error} !== 38'h0) begin
      fails++; $display("FAIL reset_outs addr=%h mfa=%b vld=%b busy=%b done=%b aerr=%b ferr=%b exp all 0",
        mif.mem_addr, mif.mem_mfa, ir_valid, busy, fetch_done, align_err, fetch_error); end
  endtask

  task automatic test_zero_wait;
    pc_in = 32'h0040_0010; fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tests++; if ({mif.mem_mfa, busy} !== 2'b11 || mif.mem_addr !== 32'h0040_0010) begin
      fails++; $display("FAIL zw_wait mfa=%b busy=%b addr=%h exp 1 1 00400010", mif.mem_mfa, busy, mif.mem_addr); end
    mif.mem_moc = 1'b1; mif.mem_data_in = 32'h8C48_FFFC;
    tick();
    mif.mem_moc = 1'b0;
    tests++; if (ir_out !== 32'h8C48_FFFC) begin fails++; $display("FAIL zw_ir got %h exp 8c48fffc", ir_out); end
    tests++; if ({opcode, rs, rt, ir_out[15:0]} !== {6'h23, 5'd2, 5'd8, 16'hFFFC}) begin
      fails++; $display("FAIL zw_fields op=%h rs=%0d rt=%0d imm=%h exp 23 2 8 fffc", opcode, rs, rt, ir_out[15:0]); end
    tests++; if ({fetch_done, ir_valid, busy, mif.mem_mfa} !== 4'b1110) begin
      fails++; $display("FAIL zw_done done/vld/busy/mfa=%b exp 1110", {fetch_done, ir_valid, busy, mif.mem_mfa}); end
    tick();
    tests++; if ({fetch_done, busy} !== 2'b00) begin fails++; $display("FAIL zw_idle done/busy=%b exp 00", {fetch_done, busy}); end
  endtask

  task automatic test_wait_states;
    int bad = 0;
    pc_in = 32'h0000_0200; fetch = 1'b1;
    tick();
    fetch = 1'b0; pc_in = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      if (mif.mem_mfa !== 1'b1 || mif.mem_addr !== 32'h0000_0200 || fetch_done !== 1'b0) bad++;
      fetch = (i == 1);
      if (i == 3) begin mif.mem_moc = 1'b1; mif.mem_data_in = 32'h0128_5020; end
      tick();
    end
    mif.mem_moc = 1'b0; fetch = 1'b1;
    tests++; if (bad != 0) begin fails++; $display("FAIL ws_hold bad_cycles=%0d exp 0", bad); end
    tests++; if ({fetch_done, mif.mem_mfa} !== 2'b10 || ir_out !== 32'h0128_5020) begin
      fails++; $display("FAIL ws_done done=%b mfa=%b ir=%h exp 1 0 01285020", fetch_done, mif.mem_mfa, ir_out); end
    tests++; if ({rd, shamt, funct} !== {5'd10, 5'd0, 6'h20}) begin
      fails++; $display("FAIL ws_fields rd=%0d sh=%0d fn=%h exp 10 0 20", rd, shamt, funct); end
    tick();
    fetch = 1'b0;
    tests++; if ({busy, mif.mem_mfa} !== 2'b00) begin fails++; $display("FAIL ws_done_fetch_ignored busy/mfa=%b exp 00", {busy, mif.mem_mfa}); end
    tick();
  endtask

  task automatic test_flush;
    pc_in = 32'h0000_0300; fetch = 1'b1;
    tick();
    fetch = 1'b0; flush = 1'b1; mif.mem_moc = 1'b1; mif.mem_data_in = 32'h1234_5678;
    tick();
    flush = 1'b0; mif.mem_moc = 1'b0;
    tests++; if (ir_out !== 32'h0 || {ir_valid, fetch_done, busy, mif.mem_mfa} !== 4'b0000) begin
      fails++; $display("FAIL flush_moc ir=%h vld/done/busy/mfa=%b exp 0 0000", ir_out, {ir_valid, fetch_done, busy, mif.mem_mfa}); end
    fetch = 1'b1; flush = 1'b1; pc_in = 32'h0000_0400;
    tick();
    fetch = 1'b0; flush = 1'b0;
    tests++; if ({busy, mif.mem_mfa} !== 2'b00 || mif.mem_addr !== 32'h0000_0300) begin
      fails++; $display("FAIL flush_fetch busy/mfa=%b addr=%h exp 00 00000300", {busy, mif.mem_mfa}, mif.mem_addr); end
  endtask

  task automatic test_align;
    pc_in = 32'h0000_0006; fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tests++; if (mif.mem_addr !== 32'h0000_0004 || align_err !== 1'b1) begin
      fails++; $display("FAIL align_set addr=%h aerr=%b exp 00000004 1", mif.mem_addr, align_err); end
    mif.mem_moc = 1'b1; mif.mem_data_in = 32'h2002_0001;
    tick(); mif.mem_moc = 1'b0; tick();
    tests++; if (align_err !== 1'b1 || ir_out !== 32'h2002_0001) begin
      fails++; $display("FAIL align_sticky aerr=%b ir=%h exp 1 20020001", align_err, ir_out); end
    pc_in = 32'h0000_0008; fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tests++; if (mif.mem_addr !== 32'h0000_0008 || align_err !== 1'b0) begin
      fails++; $display("FAIL align_clear addr=%h aerr=%b exp 00000008 0", mif.mem_addr, align_err); end
    mif.mem_moc = 1'b1; mif.mem_data_in = 32'h2003_0002;
    tick(); mif.mem_moc = 1'b0; tick();
  endtask

  task automatic test_reset_mid_wait;
    pc_in = 32'h0000_0502; fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tests++; if (mif.mem_mfa !== 1'b1 || align_err !== 1'b1) begin
      fails++; $display("FAIL rmw_pre mfa=%b aerr=%b exp 1 1", mif.mem_mfa, align_err); end
    reset = 1'b1;
    tick();
    reset = 1'b0; mif.mem_moc = 1'b1; mif.mem_data_in = 32'hDEAD_BEEF;
    tick();
    mif.mem_moc = 1'b0;
    tests++; if (ir_out !== 32'h0 || {mif.mem_addr, mif.mem_mfa, ir_valid, busy, fetch_done, align_err, fetch_error} !== 38'h0) begin
      fails++; $display("FAIL rmw_post ir=%h addr=%h mfa=%b vld=%b busy=%b done=%b aerr=%b exp all 0",
        ir_out, mif.mem_addr, mif.mem_mfa, ir_valid, busy, fetch_done, align_err); end
  endtask

  task automatic test_timeout;
    int bad = 0;
    pc_in = 32'h0000_0600; fetch = 1'b1;
    tick(); fetch = 1'b0;
    mif.mem_moc = 1'b1; mif.mem_data_in = 32'hAAAA_5555;
    tick(); mif.mem_moc = 1'b0; tick();
    pc_in = 32'h0000_0700; fetch = 1'b1;
    tick(); fetch = 1'b0;
`ifdef IR_FETCH_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      if (mif.mem_mfa !== 1'b1 || fetch_error !== 1'b0) bad++;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL to_wait bad_cycles=%0d exp 0", bad); end
    tests++; if ({fetch_error, mif.mem_mfa, fetch_done, busy} !== 4'b1000 || ir_out !== 32'hAAAA_5555) begin
      fails++; $display("FAIL to_expire ferr/mfa/done/busy=%b ir=%h exp 1000 aaaa5555",
        {fetch_error, mif.mem_mfa, fetch_done, busy}, ir_out); end
    pc_in = 32'h0000_0800; fetch = 1'b1;
    tick(); fetch = 1'b0;
    tests++; if ({fetch_error, mif.mem_mfa} !== 2'b01) begin
      fails++; $display("FAIL to_clear ferr/mfa=%b exp 01", {fetch_error, mif.mem_mfa}); end
    flush = 1'b1; tick(); flush = 1'b0;
`else
    for (int i = 0; i < 120; i++) begin
      if (mif.mem_mfa !== 1'b1 || fetch_error !== 1'b0) bad++;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL no_to_hold bad_cycles=%0d exp 0", bad); end
    flush = 1'b1; tick(); flush = 1'b0;
    tests++; if ({mif.mem_mfa, fetch_error, busy} !== 3'b000 || ir_out !== 32'h0) begin
      fails++; $display("FAIL no_to_flush mfa/ferr/busy=%b ir=%h exp 000 0", {mif.mem_mfa, fetch_error, busy}, ir_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_flush();
    test_align();
    test_reset_mid_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
